// File: rtl/fixed_point_multiplier.sv
// Sequential repeated-addition fixed-point multiplier: b * (m + f/1000).
// Define FPM_ROUND_EN to round the integer half-up and force pf to 0.
module fixed_point_multiplier #(
  parameter int SIZE = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [SIZE-1:0] m,
  input  logic [9:0]      f,
  input  logic [SIZE-1:0] b,
  output logic [SIZE-1:0] p,
  output logic [9:0]      pf,
  output logic            done,
  output logic            busy,
  output logic            err,
  output logic            ovf
);

  localparam int W = 2 * SIZE;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_ACCUM,
    S_DONE,
    S_INVALID
  } state_t;

  state_t          state_q, state_d;
  logic [SIZE-1:0] m_q, m_d;
  logic [9:0]      f_q, f_d;
  logic [SIZE-1:0] b_q, b_d;
  logic [SIZE-1:0] cnt_q, cnt_d;
  logic [W-1:0]    acci_q, acci_d;
  logic [10:0]     accf_q, accf_d;
  logic [SIZE-1:0] p_q, p_d;
  logic [9:0]      pf_q, pf_d;
  logic            err_q, err_d;
  logic            ovf_q, ovf_d;

  logic [10:0]     t;
  logic            carry;
  logic [10:0]     accf_n;
  logic [W-1:0]    acci_n;
  logic [SIZE-1:0] res_p;
  logic [9:0]      res_pf;
  logic            res_ovf;

  // One fractional add with carry into the integer accumulator
  always_comb begin
    t      = accf_q + {1'b0, f_q};
    carry  = (t >= 11'd1000);
    accf_n = carry ? (t - 11'd1000) : t;
    acci_n = acci_q
           + {{SIZE{1'b0}}, m_q}
           + {{(W-1){1'b0}}, carry};
  end

`ifdef FPM_ROUND_EN
  logic [W:0] rnd;

  always_comb begin
    rnd = {1'b0, acci_n}
        + {{W{1'b0}}, (accf_n >= 11'd500)};
    res_p   = rnd[SIZE-1:0];
    res_pf  = 10'd0;
    res_ovf = |rnd[W:SIZE];
  end
`else
  always_comb begin
    res_p   = acci_n[SIZE-1:0];
    res_pf  = accf_n[9:0];
    res_ovf = |acci_n[W-1:SIZE];
  end
`endif

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    f_d     = f_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    acci_d  = acci_q;
    accf_d  = accf_q;
    p_d     = p_q;
    pf_d    = pf_q;
    err_d   = err_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          m_d     = m;
          f_d     = f;
          b_d     = b;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        acci_d = '0;
        accf_d = '0;
        if (f_q > 10'd999) begin
          p_d     = '0;
          pf_d    = '0;
          ovf_d   = 1'b0;
          err_d   = 1'b1;
          state_d = S_INVALID;
        end else if (b_q == '0 ||
                     (m_q == '0 && f_q == '0)) begin
          p_d     = '0;
          pf_d    = '0;
          ovf_d   = 1'b0;
          err_d   = 1'b0;
          state_d = S_DONE;
        end else begin
          cnt_d   = b_q;
          state_d = S_ACCUM;
        end
      end
      S_ACCUM: begin
        acci_d = acci_n;
        accf_d = accf_n;
        cnt_d  = cnt_q - SIZE'(1);
        // Result lands in output regs together with entry to DONE
        if (cnt_q == SIZE'(1)) begin
          p_d     = res_p;
          pf_d    = res_pf;
          ovf_d   = res_ovf;
          err_d   = 1'b0;
          state_d = S_DONE;
        end
      end
      S_DONE:    state_d = S_IDLE;
      S_INVALID: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      m_q     <= '0;
      f_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      acci_q  <= '0;
      accf_q  <= '0;
      p_q     <= '0;
      pf_q    <= '0;
      err_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      f_q     <= f_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      acci_q  <= acci_d;
      accf_q  <= accf_d;
      p_q     <= p_d;
      pf_q    <= pf_d;
      err_q   <= err_d;
      ovf_q   <= ovf_d;
    end
  end

  assign p    = p_q;
  assign pf   = pf_q;
  assign err  = err_q;
  assign ovf  = ovf_q;
  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_DONE) ||
                (state_q == S_INVALID);

endmodule

// File: tb/tb_fixed_point_multiplier.sv
// Scoreboard bench for fixed_point_multiplier (SIZE=4).
// Expected results are hand-computed; FPM_ROUND_EN selects the rounded set.
module tb_fixed_point_multiplier;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [3:0] m = '0;
  logic [9:0] f = '0;
  logic [3:0] b = '0;
  logic [3:0] p;
  logic [9:0] pf;
  logic       done, busy, err, ovf;

  fixed_point_multiplier #(.SIZE(4)) dut (
    .clk(clk), .rst(rst), .start(start),
    .m(m), .f(f), .b(b),
    .p(p), .pf(pf), .done(done),
    .busy(busy), .err(err), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] p;
    logic [9:0] pf;
    logic       err;
    logic       ovf;
    int         lat;
    int         se;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   passes = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act,
                     input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d",
                  nm, act, exp);
  endtask

  function automatic exp_t mk(input int pi, input int pfi,
                              input int ei, input int oi,
                              input int li);
    exp_t e;
    e.p = 4'(pi); e.pf = 10'(pfi);
    e.err = ei[0]; e.ovf = oi[0];
    e.lat = li; e.se = 0;
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest expectation
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("p", int'(p), int'(e.p));
        chk("pf", int'(pf), int'(e.pf));
        chk("err", int'(err), int'(e.err));
        chk("ovf", int'(ovf), int'(e.ovf));
        chk("latency", cyc - e.se + 1, e.lat);
      end
    end
  end

  task automatic issue(input int mi, input int fi,
                       input int bi, input exp_t e,
                       input bit track);
    int n = 0;
    @(negedge clk);
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("idle_timeout", 1, 0);
    m = 4'(mi); f = 10'(fi); b = 4'(bi);
    start = 1'b1;
    e.se = cyc + 1;
    if (track) sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", int'(busy), 1);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      chk("done_timeout", 1, 0);
      sb.delete();
    end
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_p"}, int'(p), 0);
    chk({tag, "_pf"}, int'(pf), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_err"}, int'(err), 0);
    chk({tag, "_ovf"}, int'(ovf), 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk_cleared("reset");
    rst = 1'b0;

`ifdef FPM_ROUND_EN
    issue(3, 500, 2, mk(7, 0, 0, 0, 4), 1);
    issue(3, 333, 3, mk(10, 0, 0, 0, 5), 1);
    issue(2, 125, 4, mk(9, 0, 0, 0, 6), 1);
    issue(15, 999, 15, mk(0, 0, 0, 1, 17), 1);
    issue(1, 1, 1, mk(1, 0, 0, 0, 3), 1);
`else
    issue(3, 500, 2, mk(7, 0, 0, 0, 4), 1);
    issue(3, 333, 3, mk(9, 999, 0, 0, 5), 1);
    issue(2, 125, 4, mk(8, 500, 0, 0, 6), 1);
    issue(15, 999, 15, mk(15, 985, 0, 1, 17), 1);
    issue(1, 1, 1, mk(1, 1, 0, 0, 3), 1);
`endif
    drain();
    issue(0, 0, 3, mk(0, 0, 0, 0, 2), 1);
    issue(7, 250, 0, mk(0, 0, 0, 0, 2), 1);
    drain();

    // Invalid fraction with a start pulse while busy
    issue(1, 1000, 3, mk(0, 0, 1, 0, 2), 1);
    m = 4'd2; f = 10'd0; b = 4'd2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain();
    repeat (4) @(negedge clk);
    issue(0, 1023, 0, mk(0, 0, 1, 0, 2), 1);
    drain();

    issue(15, 0, 3, mk(13, 0, 0, 1, 5), 1);
    drain();

    // Abort mid-ACCUM: outputs from the overflow case get cleared
    issue(5, 0, 9, mk(0, 0, 0, 0, 0), 0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 chk_cleared("mid_reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    chk("no_done_after_abort", int'(busy), 0);

    issue(5, 0, 2, mk(10, 0, 0, 0, 4), 1);
    drain();
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/fixed_point_multiplier.md
Name: fixed_point_multiplier

Overview:
- Sequential repeated-addition multiplier; the inverse of the team's fixed-point divider.
- Takes a quotient in divider output format and a multiplier `b`:
  - integer part `m`
  - fraction `f` in thousandths, 0..999
- Reconstructs `b*(m + f/1000)` as an integer part plus a thousandths fraction.
- Sits downstream of the divider for round-trip checking and for fixed-point scaling in the datapath.

Parameters:
- SIZE, 4, width of `m`, `b` and the integer product `p`.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  begin operation; sampled only in IDLE.
- m  input  SIZE  integer part of multiplicand.
- f  input  10  fraction of multiplicand, thousandths (legal 0..999).
- b  input  SIZE  unsigned multiplier.
- p  output  SIZE  integer part of product, low SIZE bits.
- pf  output  10  fraction of product, thousandths, 0..999.
- done  output  1  one-cycle pulse; result or error valid.
- busy  output  1  high in every state except IDLE.
- err  output  1  invalid fraction input; valid with `done`.
- ovf  output  1  integer product exceeded SIZE bits; valid with `done`.

Behaviour:
- Reset (async, any state, mid-operation included):
  - state is IDLE.
  - `p`, `pf`, `done`, `busy`, `err`, `ovf` and all accumulators are 0.
  - Any in-flight operation is aborted; no `done` is issued for it.
- Registers:
  - `m_r`, `f_r`, `b_r` hold the captured operands.
  - `cnt` is SIZE bits.
  - `acc_i` is 2*SIZE bits.
  - `acc_f` is 11 bits.
- IDLE:
  - If `start`=1 at a rising edge, capture `m`, `f`, `b` into `m_r`, `f_r`, `b_r` and go to CHECK.
  - Operands are sampled only on that edge; later input changes are ignored.
- CHECK (1 cycle), in priority order:
  1. `f_r`>999 → INVALID.
  2. `b_r`==0, or (`m_r`==0 and `f_r`==0) → DONE with `acc_i`=0, `acc_f`=0.
  3. Otherwise → ACCUM with `acc_i`=0, `acc_f`=0, `cnt`=`b_r`.
- ACCUM (one addition per cycle):
  - `t` = `acc_f` + `f_r`.
  - If `t`>=1000: `acc_f`=`t`-1000 and carry=1; else `acc_f`=`t` and carry=0.
  - `acc_i` = `acc_i` + `m_r` + carry.
  - `cnt` = `cnt`-1; when `cnt` was 1 → DONE.
  - Exactly `b_r` ACCUM cycles are spent.
- DONE (1 cycle):
  - `p` = `acc_i[SIZE-1:0]`, `pf` = `acc_f[9:0]`.
  - `ovf` = OR of `acc_i[2*SIZE-1:SIZE]`; `err`=0; `done`=1.
  - Next state is IDLE.
- INVALID (1 cycle):
  - `p`=0, `pf`=0, `ovf`=0, `err`=1, `done`=1.
  - Next state is IDLE.
- Output timing:
  - `p`, `pf`, `err`, `ovf` are registered, updated in DONE/INVALID.
  - They hold their values until the next DONE/INVALID or reset.
  - `done` is high only in DONE/INVALID.
- Latency, counting from the start-sampling edge to `done` high:
  - normal: `b`+2 edges.
  - zero or invalid: 2 edges.
- `start` while `busy`: ignored, no queueing. `start` held high through DONE: a new operation is accepted on the first IDLE edge.
- Width rules:
  - `acc_i` cannot overflow 2*SIZE bits, since max (2^SIZE-1)*(2^SIZE-1) + carries < 2^(2*SIZE).
  - `acc_f` never exceeds 1998 before correction.

Optional Feature:
- Macro `FPM_ROUND_EN`.
- Defined:
  - DONE applies round-half-up to the integer: if `acc_f`>=500, `p` = (`acc_i`+1)[SIZE-1:0].
  - `ovf` is computed on the rounded value.
  - `pf` is forced to 0.
- Not defined:
  - Truncated behaviour exactly as in Behaviour.
  - `pf` carries the fraction.
- Latency is identical in both builds.

Test Plan:
- Reset mid-ACCUM: `m`=5, `f`=0, `b`=9, `start`; assert `rst` on 3rd cycle → `done` never pulses, all outputs 0, IDLE, next `start` works normally.
- Round-trip: `m`=3, `f`=500, `b`=2 → `done` after 4 edges.
  - Without macro: `p`=7, `pf`=0, `err`=0, `ovf`=0.
  - With `FPM_ROUND_EN`: `p`=7, `pf`=0.
- Repeating fraction: `m`=3, `f`=333, `b`=3 → `done` after 5 edges.
  - Without macro: `p`=9, `pf`=999.
  - With macro: `p`=10, `pf`=0.
- Zero cases:
  - `m`=0, `f`=0, `b`=3 → `done` after 2 edges, `p`=0, `pf`=0.
  - `m`=7, `f`=250, `b`=0 → same.
- Invalid fraction: `m`=1, `f`=1000, `b`=3 → `done` after 2 edges, `err`=1, `p`=0, `pf`=0; `start` pulsed during `busy` is ignored.
- Overflow (SIZE=4): `m`=15, `f`=0, `b`=3 → `done` after 5 edges, `p`=13 (45 mod 16), `pf`=0, `ovf`=1.
